bs_job_sequencer: RTL and testbench

//  Upstream job controller for the Black-Scholes pricing core (top: d1d2 -> norm -> OptionPrice).

---
 rtl/bs_job_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_bs_job_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_job_sequencer.sv
// -----------------------------------------------------------------------------
// bs_job_sequencer
//   Upstream job controller for the Black-Scholes pricing core. Option
//   parameter sets arrive over a valid/ready handshake and are queued in a
//   small FIFO. Each set is validated when it leaves the FIFO. A valid set is
//   driven onto the core inputs and held for LATENCY cycles, and then
//   core_price is captured. An invalid set skips the core and produces an
//   error result. Results leave over a second valid/ready handshake, in order.
//
//   The core has no start/done strobes. The fixed settle count is the only
//   synchronisation with it.
//
// Parameters
//   WIDTH    data width (signed Q16.16 prices and parameters)
//   DEPTH    FIFO entries (power of 2, >= 2)
//   LATENCY  cycles the core inputs are held before sampling (>= 2)
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   job_valid/job_ready        job handshake (job_ready = FIFO not full)
//   job_spot..job_rate         job parameters; job_otype 0 = call, 1 = put
//   core_spot..core_otype      registered parameters driven to the core
//   core_price                 price returned by the core
//   res_valid/res_ready        result handshake
//   res_price                  captured price, or 0 for a rejected job
//   res_otype, res_err         option type of the job; validation failure flag
//   busy                       FSM active or FIFO non-empty
//
// Build option
//   BS_SEQ_TAG_EN  adds job_tag[7:0] / res_tag[7:0]. The tag travels with
//                  each job and is echoed with its result.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module bs_job_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [WIDTH-1:0] job_spot,
  input  logic [WIDTH-1:0] job_strike,
  input  logic [WIDTH-1:0] job_timetm,
  input  logic [WIDTH-1:0] job_sigma,
  input  logic [WIDTH-1:0] job_rate,
  input  logic             job_otype,
  output logic [WIDTH-1:0] core_spot,
  output logic [WIDTH-1:0] core_strike,
  output logic [WIDTH-1:0] core_timetm,
  output logic [WIDTH-1:0] core_sigma,
  output logic [WIDTH-1:0] core_rate,
  output logic             core_otype,
  input  logic [WIDTH-1:0] core_price,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_price,
  output logic             res_otype,
  output logic             res_err,
`ifdef BS_SEQ_TAG_EN
  input  logic [7:0]       job_tag,
  output logic [7:0]       res_tag,
`endif
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY);

  typedef struct packed {
    logic [WIDTH-1:0] spot;
    logic [WIDTH-1:0] strike;
    logic [WIDTH-1:0] timetm;
    logic [WIDTH-1:0] sigma;
    logic [WIDTH-1:0] rate;
    logic             otype;
`ifdef BS_SEQ_TAG_EN
    logic [7:0]       tag;
`endif
  } job_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_ERR} state_t;

  // Strictly positive in two's complement: sign clear and not zero.
  function automatic logic is_pos(input logic [WIDTH-1:0] v);
    return !v[WIDTH-1] && (|v);
  endfunction

  // ---------------------------------------------------------------- FIFO ----
  job_t           mem_q [DEPTH];
  job_t           job_in;
  job_t           head;
  logic [AW:0]    wr_ptr_q, rd_ptr_q;   // extra MSB separates full from empty
  logic           empty, full, push, pop;

  // NOTE: a combinational block assigns every variable it writes on every
  // path. Here every field is written, and elsewhere defaults come first,
  // so no latches are inferred.
  always_comb begin
    job_in.spot   = job_spot;
    job_in.strike = job_strike;
    job_in.timetm = job_timetm;
    job_in.sigma  = job_sigma;
    job_in.rate   = job_rate;
    job_in.otype  = job_otype;
`ifdef BS_SEQ_TAG_EN
    job_in.tag    = job_tag;
`endif
  end

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Ready depends only on the registered fill level. A pop in the same
  // cycle does not reopen the input until the next cycle.
  assign job_ready = !full;
  assign push      = job_valid && !full;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage arrays carry no reset. The pointers alone decide which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= job_in;
  end

  // NOTE: sequential state uses non-blocking assignments only. All
  // registers then update together at the edge, with no ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ----------------------------------------------------------------- FSM ----
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            head_ok, launch, cap_ok, cap_err, res_free;

  assign head_ok  = is_pos(head.spot) && is_pos(head.strike) &&
                    is_pos(head.timetm) && is_pos(head.sigma);
  // The result register counts as free when it is empty, or when it is
  // being drained in this same cycle.
  assign res_free = !res_valid || res_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    launch  = 1'b0;
    cap_ok  = 1'b0;
    cap_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_ok) begin
            launch  = 1'b1;
            cnt_d   = CW'(LATENCY - 1);
            state_d = S_RUN;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          if (res_free) begin
            cap_ok  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (res_free) begin
          cap_ok  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (res_free) begin
          cap_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [7:0] cur_tag_q;      // tag of the job in flight (unused without tags)
  logic       cur_otype_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_otype_q <= 1'b0;
      cur_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        cur_otype_q <= head.otype;
`ifdef BS_SEQ_TAG_EN
        cur_tag_q   <= head.tag;
`endif
      end
    end
  end

  // ------------------------------------------------------ core registers ----
  // Loaded only when a valid job launches. Rejected jobs leave them alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_spot   <= '0;
      core_strike <= '0;
      core_timetm <= '0;
      core_sigma  <= '0;
      core_rate   <= '0;
      core_otype  <= 1'b0;
    end else if (launch) begin
      core_spot   <= head.spot;
      core_strike <= head.strike;
      core_timetm <= head.timetm;
      core_sigma  <= head.sigma;
      core_rate   <= head.rate;
      core_otype  <= head.otype;
    end
  end

  // ----------------------------------------------------- result register ----
  logic [7:0] res_tag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_price <= '0;
      res_otype <= 1'b0;
      res_err   <= 1'b0;
      res_tag_q <= '0;
    end else if (cap_ok || cap_err) begin
      // A load takes priority over a drain in the same cycle.
      res_valid <= 1'b1;
      res_price <= cap_ok ? core_price : '0;
      res_err   <= cap_err;
      res_otype <= cur_otype_q;
      res_tag_q <= cur_tag_q;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef BS_SEQ_TAG_EN
  assign res_tag = res_tag_q;
`else
  // Tag path is idle without the option; the reduction silences its bits.
  logic unused_tag;
  assign unused_tag = ^{cur_tag_q, res_tag_q};
`endif

  assign busy = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_bs_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bs_job_sequencer
//   Directed and randomized bench for bs_job_sequencer. A stub core returns a
//   fixed arithmetic function of its inputs, or a pinned constant. A queue
//   model predicts every result from the job-level rules: in-order, one
//   result per accepted job, price 0 with err for rejected jobs. A second
//   queue predicts the sequence of parameter sets driven to the core.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bs_job_sequencer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 48;

  logic         clk = 1'b0;
  logic         reset;
  logic         job_valid, job_ready;
  logic [W-1:0] job_spot, job_strike, job_timetm, job_sigma, job_rate;
  logic         job_otype;
  logic [7:0]   job_tag;
  logic [W-1:0] core_spot, core_strike, core_timetm, core_sigma, core_rate;
  logic         core_otype;
  logic [W-1:0] core_price;
  logic         res_valid, res_ready;
  logic [W-1:0] res_price;
  logic         res_otype, res_err, busy;
`ifdef BS_SEQ_TAG_EN
  logic [7:0]   res_tag;
`endif

  always #5 clk = ~clk;

  bs_job_sequencer #(.WIDTH(W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_spot(job_spot), .job_strike(job_strike), .job_timetm(job_timetm),
    .job_sigma(job_sigma), .job_rate(job_rate), .job_otype(job_otype),
    .core_spot(core_spot), .core_strike(core_strike), .core_timetm(core_timetm),
    .core_sigma(core_sigma), .core_rate(core_rate), .core_otype(core_otype),
    .core_price(core_price),
    .res_valid(res_valid), .res_ready(res_ready), .res_price(res_price),
    .res_otype(res_otype), .res_err(res_err),
`ifdef BS_SEQ_TAG_EN
    .job_tag(job_tag), .res_tag(res_tag),
`endif
    .busy(busy)
  );

  // ------------------------------------------------------------ checking ----
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ----------------------------------------------------------- stub core ----
  bit pin_price;   // when set, the core returns a fixed constant
  function automatic logic [31:0] price_fn(input logic [31:0] s, k, t, v, r, input logic o);
    return (s ^ {k[15:0], k[31:16]}) + (t * 32'd3) + v - r + {31'd0, o};
  endfunction

  always_comb core_price = pin_price ? 32'h0006AB12
                                     : price_fn(core_spot, core_strike, core_timetm,
                                                core_sigma, core_rate, core_otype);

  // --------------------------------------------------------------- model ----
  typedef struct {
    logic [31:0] price;
    logic        err;
    logic        otype;
    logic [7:0]  tag;
  } exp_t;

  typedef struct packed {
    logic [31:0] spot, strike, timetm, sigma, rate;
    logic        otype;
  } params_t;

  exp_t    exp_q[$];
  params_t launch_q[$];
  params_t core_prev, core_now, p_in, p_exp;
  exp_t    e_in, e_out;
  bit      mon_en;
  bit      ok_in;
  int      results_seen = 0;

  // Inputs change only just after a rising edge, so the values seen at the
  // falling edge are the ones the next rising edge acts on.
  always @(negedge clk) begin
    core_now = '{core_spot, core_strike, core_timetm, core_sigma, core_rate, core_otype};
    if (reset) begin
      if (job_valid && job_ready) begin
        ok_in = ($signed(job_spot) > 0) && ($signed(job_strike) > 0) &&
                ($signed(job_timetm) > 0) && ($signed(job_sigma) > 0);
        p_in  = '{job_spot, job_strike, job_timetm, job_sigma, job_rate, job_otype};
        e_in.price = !ok_in ? 32'd0 :
                     pin_price ? 32'h0006AB12 :
                     price_fn(job_spot, job_strike, job_timetm, job_sigma, job_rate, job_otype);
        e_in.err   = !ok_in;
        e_in.otype = job_otype;
        e_in.tag   = job_tag;
        exp_q.push_back(e_in);
        if (ok_in && mon_en) launch_q.push_back(p_in);
      end
      if (res_valid && res_ready) begin
        results_seen++;
        if (exp_q.size() == 0) begin
          check("result_without_job", {31'd0, res_valid}, 32'd0);
        end else begin
          e_out = exp_q.pop_front();
          check("res_price", res_price, e_out.price);
          check("res_err", {31'd0, res_err}, {31'd0, e_out.err});
          check("res_otype", {31'd0, res_otype}, {31'd0, e_out.otype});
`ifdef BS_SEQ_TAG_EN
          check("res_tag", {24'd0, res_tag}, {24'd0, e_out.tag});
`endif
        end
      end
      if (mon_en && (core_now != core_prev)) begin
        if (launch_q.size() == 0) begin
          check("core_change_without_launch", {31'd0, core_now != core_prev}, 32'd0);
        end else begin
          p_exp = launch_q.pop_front();
          check("core_spot_launch", core_spot, p_exp.spot);
          check("core_strike_launch", core_strike, p_exp.strike);
          check("core_sigma_launch", core_sigma, p_exp.sigma);
          check("core_rate_launch", core_rate, p_exp.rate);
        end
      end
    end
    core_prev = core_now;
  end

  // ------------------------------------------------------------- helpers ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input logic [31:0] s, k, t, v, r, input logic o, input logic [7:0] g);
    job_spot = s; job_strike = k; job_timetm = t; job_sigma = v; job_rate = r;
    job_otype = o; job_tag = g;
  endtask

  // Presents the job already loaded by set_job and returns just after the
  // edge that accepts it.
  task automatic push_job(input string tag);
    int n = 0;
    job_valid = 1'b1;
    while (!job_ready && n < 4 * LAT) begin
      tick();
      n++;
    end
    check({tag, "_accept_timeout"}, {31'd0, n < 4 * LAT}, 32'd1);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_drain_timeout"}, {31'd0, n < bound}, 32'd1);
  endtask

  // ------------------------------------------------------------ stimulus ----
  initial begin
    int lat;
    int acc;
    int n;
    int pushed;
    int stale;
    int base_seen;
    logic [31:0] rv;

    reset = 1'b0; job_valid = 1'b0; res_ready = 1'b0;
    pin_price = 1'b0; mon_en = 1'b0;
    set_job('0, '0, '0, '0, '0, 1'b0, 8'h00);
    repeat (3) tick();

    // Reset state: all outputs low, except that the FIFO offers space.
    check("rst_job_ready", {31'd0, job_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_core_spot", core_spot, 32'd0);
    check("rst_core_otype", {31'd0, core_otype}, 32'd0);
    check("rst_res_price", res_price, 32'd0);
    check("rst_res_err", {31'd0, res_err}, 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Single call. Counting the push cycle as cycle 0, res_valid is first
    // high in cycle LATENCY+2, i.e. LATENCY+1 edges after the push edge.
    pin_price = 1'b1;
    res_ready = 1'b1;
    set_job(32'h00640000, 32'h00640000, 32'h00010000, 32'h00003333, 32'h00000CCD, 1'b0, 8'h01);
    push_job("single");
    check("single_busy", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!res_valid && lat < 4 * LAT) begin
      tick();
      lat++;
    end
    check("single_latency", lat, LAT + 1);
    check("single_price", res_price, 32'h0006AB12);
    check("single_err", {31'd0, res_err}, 32'd0);
    drain("single", 4 * LAT);
    pin_price = 1'b0;

    // A rejected job (spot = 0) produces an error result quickly and leaves
    // the core inputs alone.
    set_job(32'h00000000, 32'h00640000, 32'h00010000, 32'h00004000, 32'h00000100, 1'b1, 8'h02);
    push_job("err");
    lat = 0;
    while (!res_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("err_within_3", {31'd0, lat <= 3}, 32'd1);
    check("err_flag", {31'd0, res_err}, 32'd1);
    check("err_price", res_price, 32'd0);
    check("err_otype", {31'd0, res_otype}, 32'd1);
    check("err_core_spot_kept", core_spot, 32'h00640000);
    check("err_core_sigma_kept", core_sigma, 32'h00003333);
    set_job(32'h00C80000, 32'h00640000, 32'h00020000, 32'h00004000, 32'hFFFF8000, 1'b0, 8'h03);
    push_job("after_err");
    drain("after_err", 4 * LAT);
    check("after_err_core_spot", core_spot, 32'h00C80000);

    // Back-pressure: the consumer stalls while six jobs are offered.
    res_ready = 1'b0;
    base_seen = results_seen;
    acc = 0;
    job_valid = 1'b1;
    n = 0;
    while (n < 20) begin
      set_job(32'h00010000 * (acc + 1), 32'h00500000, 32'h00008000, 32'h00002000, 32'h00000400, acc[0], 8'h40 + 8'(acc));
      if (!job_ready) break;
      tick();
      acc++;
      n++;
    end
    check("bp_accepted_before_full", acc, DEPTH + 1);
    n = 0;
    while (!job_ready && n < 4 * LAT) begin
      tick();
      n++;
    end
    check("bp_sixth_timeout", {31'd0, n < 4 * LAT}, 32'd1);
    tick();
    job_valid = 1'b0;
    repeat (LAT + 5) tick();
    // Job 1 still owns the result register, and job 2 waits behind it.
    check("bp_res_valid", {31'd0, res_valid}, 32'd1);
    check("bp_res_price_job1",
          res_price, price_fn(32'h00010000, 32'h00500000, 32'h00008000, 32'h00002000, 32'h00000400, 1'b0));
    check("bp_fifo_full", {31'd0, job_ready}, 32'd0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    drain("bp", 12 * LAT);
    check("bp_result_count", results_seen - base_seen, 6);

    // Randomized traffic. The job inputs change every cycle, so any core
    // input change that is not a launch is caught by the launch monitor.
    mon_en = 1'b1;
    pushed = 0;
    n = 0;
    while (pushed < 40 && n < 20000) begin
      set_job($urandom & 32'h7FFFFFFF | 32'd1, $urandom & 32'h7FFFFFFF | 32'd1,
              $urandom & 32'h7FFFFFFF | 32'd1, $urandom & 32'h7FFFFFFF | 32'd1,
              $urandom, 1'($urandom), 8'($urandom));
      if ($urandom_range(0, 99) < 15) begin
        rv = $urandom_range(0, 1) ? 32'd0 : ($urandom | 32'h80000000);
        case ($urandom_range(0, 3))
          0: job_spot   = rv;
          1: job_strike = rv;
          2: job_timetm = rv;
          default: job_sigma = rv;
        endcase
      end
      job_valid = ($urandom_range(0, 99) < 60);
      res_ready = ($urandom_range(0, 99) < 70);
      if (job_valid && job_ready) pushed++;
      tick();
      n++;
    end
    job_valid = 1'b0;
    check("rand_push_timeout", {31'd0, pushed == 40}, 32'd1);
    drain("rand", 60 * LAT);
    check("rand_launch_queue_empty", launch_q.size(), 0);
    mon_en = 1'b0;

`ifdef BS_SEQ_TAG_EN
    // Tags follow their jobs, error results included.
    res_ready = 1'b1;
    set_job(32'h00100000, 32'h00100000, 32'h00010000, 32'h00001000, 32'h0, 1'b0, 8'h11);
    push_job("tag1");
    set_job(32'h00100000, 32'h00100000, 32'h00010000, 32'h00000000, 32'h0, 1'b1, 8'h22);
    push_job("tag2");
    set_job(32'h00200000, 32'h00100000, 32'h00010000, 32'h00001000, 32'h0, 1'b0, 8'h33);
    push_job("tag3");
    drain("tag", 8 * LAT);
    check("tag_last", {24'd0, res_tag}, 32'h33);
`endif

    // Reset while a job is running with the counter at 10.
    res_ready = 1'b1;
    set_job(32'h00300000, 32'h00280000, 32'h00018000, 32'h00002800, 32'h00000200, 1'b1, 8'h55);
    push_job("mid_rst");
    repeat (LAT - 10) tick();
    check("mid_rst_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    launch_q.delete();
    check("mid_rst_job_ready", {31'd0, job_ready}, 32'd1);
    check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_core_spot", core_spot, 32'd0);
    check("mid_rst_core_otype", {31'd0, core_otype}, 32'd0);
    check("mid_rst_res_price", res_price, 32'd0);
    tick();
    reset = 1'b1;
    stale = 0;
    repeat (LAT + 10) begin
      tick();
      if (res_valid || busy) stale++;
    end
    check("mid_rst_no_stale", stale, 0);
    check("all_results_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
